// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the two-master data-memory bus arbiter.
// State encodings, master indices and bus direction constants.
package data_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam int M_CPU = 0;
   localparam int M_AUX = 1;

   localparam logic WR = 1'b1;
   localparam logic RD = 1'b0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the preference pointer flips to the loser after each grant.
// Winner is combinational from req and the registered pointer.
module rr_arbiter2
   import data_bus_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] winner
);

   logic ptr;  // 0: m0 preferred on a tie, 1: m1 preferred

   always_comb begin
      winner = 2'b00;
      case (req)
         2'b01:   winner = 2'b01;
         2'b10:   winner = 2'b10;
         2'b11:   winner = ptr ? 2'b10 : 2'b01;
         default: winner = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (advance && (|winner)) begin
         ptr <= winner[M_CPU];
      end
   end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares one data-memory bus between the cpu data port (m0) and an auxiliary master (m1).
// Per-transaction FSM IDLE->ACCESS->RESP with WAIT_STATES extra access cycles; all outputs registered.
module data_bus_arbiter
   import data_bus_arbiter_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_wr_rd,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_ready,
   input  logic              m1_req,
   input  logic              m1_wr_rd,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_ready,
   output logic              CS,
   output logic              WR_RD,
   output logic [ADDR_W-1:0] ADDR,
   output logic [DATA_W-1:0] Data_BUS_WRITE,
   input  logic [DATA_W-1:0] Data_BUS_READ,
   output logic [1:0]        gnt
);

   localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       req;
   logic [1:0]       winner;
   logic             grant;
   logic             last_cycle;

   assign req        = {m1_req, m0_req};
   assign grant      = (state == ST_IDLE) && (|req);
   assign last_cycle = (state == ST_ACCESS) && (cnt == '0);

   rr_arbiter2 u_rr (
      .clk    (CLK),
      .rst_n  (reset),
      .req    (req),
      .advance(grant),
      .winner (winner)
   );

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (|req) state_nxt = ST_ACCESS;
         ST_ACCESS: if (cnt == '0) state_nxt = ST_RESP;
         ST_RESP:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // The bus output registers double as the request latch; gnt remembers the owner until RESP.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         cnt            <= '0;
         CS             <= 1'b0;
         WR_RD          <= 1'b0;
         ADDR           <= '0;
         Data_BUS_WRITE <= '0;
         gnt            <= 2'b00;
         m0_ready       <= 1'b0;
         m1_ready       <= 1'b0;
         m0_rdata       <= '0;
         m1_rdata       <= '0;
      end else begin
         m0_ready <= 1'b0;
         m1_ready <= 1'b0;
         if (grant) begin
            cnt <= CNT_W'(WAIT_STATES);
            CS  <= 1'b1;
            gnt <= winner;
            if (winner[M_AUX]) begin
               WR_RD          <= m1_wr_rd;
               ADDR           <= m1_addr;
               Data_BUS_WRITE <= (m1_wr_rd == WR) ? m1_wdata : '0;
            end else begin
               WR_RD          <= m0_wr_rd;
               ADDR           <= m0_addr;
               Data_BUS_WRITE <= (m0_wr_rd == WR) ? m0_wdata : '0;
            end
         end else if (last_cycle) begin
            CS             <= 1'b0;
            WR_RD          <= 1'b0;
            ADDR           <= '0;
            Data_BUS_WRITE <= '0;
            gnt            <= 2'b00;
            if (gnt[M_AUX]) begin
               m1_ready <= 1'b1;
               if (WR_RD == RD) m1_rdata <= Data_BUS_READ;
            end else begin
               m0_ready <= 1'b1;
               if (WR_RD == RD) m0_rdata <= Data_BUS_READ;
            end
         end else if (state == ST_ACCESS) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench: cycle table for single transactions, hand sequences for arbitration and reset.
module tb_data_bus_arbiter;

   logic        CLK = 1'b0;
   logic        reset;
   logic        m0_req, m0_wr_rd, m1_req, m1_wr_rd;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, dbr;

   logic [31:0] m0_rdata, m1_rdata, addr, dbw;
   logic        m0_ready, m1_ready, cs, wr_rd;
   logic [1:0]  gnt;

   logic [31:0] z_m0_rdata, z_m1_rdata, z_addr, z_dbw;
   logic        z_m0_ready, z_m1_ready, z_cs, z_wr_rd;
   logic [1:0]  z_gnt;

   int n_tests = 0;
   int n_fail  = 0;
   int bad_gnt = 0;

   always #5 CLK = ~CLK;

   data_bus_arbiter #(.DATA_W(32), .ADDR_W(32), .WAIT_STATES(2)) dut (
      .CLK(CLK), .reset(reset),
      .m0_req(m0_req), .m0_wr_rd(m0_wr_rd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata), .m0_ready(m0_ready),
      .m1_req(m1_req), .m1_wr_rd(m1_wr_rd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata), .m1_ready(m1_ready),
      .CS(cs), .WR_RD(wr_rd), .ADDR(addr), .Data_BUS_WRITE(dbw),
      .Data_BUS_READ(dbr), .gnt(gnt)
   );

   data_bus_arbiter #(.DATA_W(32), .ADDR_W(32), .WAIT_STATES(0)) dut_z (
      .CLK(CLK), .reset(reset),
      .m0_req(m0_req), .m0_wr_rd(m0_wr_rd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(z_m0_rdata), .m0_ready(z_m0_ready),
      .m1_req(m1_req), .m1_wr_rd(m1_wr_rd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(z_m1_rdata), .m1_ready(z_m1_ready),
      .CS(z_cs), .WR_RD(z_wr_rd), .ADDR(z_addr), .Data_BUS_WRITE(z_dbw),
      .Data_BUS_READ(dbr), .gnt(z_gnt)
   );

   typedef struct {
      logic        m0_req, m0_wr;
      logic [31:0] m0_addr, m0_wdata;
      logic        m1_req, m1_wr;
      logic [31:0] m1_addr, m1_wdata, dbr;
      logic        e_cs, e_wr;
      logic [31:0] e_addr, e_dbw;
      logic [1:0]  e_gnt;
      logic        e_r0, e_r1;
      logic [31:0] e_rd0, e_rd1;
   } vec_t;

   localparam int NV = 17;
   vec_t vt [NV];

   function automatic vec_t mk(
      input logic r0q, input logic r0w, input logic [31:0] a0, input logic [31:0] d0,
      input logic r1q, input logic r1w, input logic [31:0] a1, input logic [31:0] d1,
      input logic [31:0] rd,
      input logic ecs, input logic ewr, input logic [31:0] ea, input logic [31:0] ed,
      input logic [1:0] eg, input logic er0, input logic er1,
      input logic [31:0] erd0, input logic [31:0] erd1);
      vec_t v;
      v.m0_req = r0q; v.m0_wr = r0w; v.m0_addr = a0; v.m0_wdata = d0;
      v.m1_req = r1q; v.m1_wr = r1w; v.m1_addr = a1; v.m1_wdata = d1;
      v.dbr = rd;
      v.e_cs = ecs; v.e_wr = ewr; v.e_addr = ea; v.e_dbw = ed; v.e_gnt = eg;
      v.e_r0 = er0; v.e_r1 = er1; v.e_rd0 = erd0; v.e_rd1 = erd1;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // which=0 waits for CS, which=1 waits for any ready pulse
   task automatic wait_for(input int which, input string name);
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 20 && !hit; k++) begin
         @(posedge CLK); #1;
         if (gnt == 2'b11) bad_gnt++;
         hit = (which == 0) ? cs : (m0_ready | m1_ready);
      end
      check({name, " timeout"}, 32'(hit), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //        m0: req wr addr      wdata      m1: req wr addr      wdata      dbr          exp: cs wr addr      dbw        gnt    r0 r1 rd0        rd1
      vt[0]  = mk(0, 0, 32'h0,  32'h0,      0, 0, 32'h0,  32'h0,      32'h0,       0, 0, 32'h0,  32'h0,      2'b00, 0, 0, 32'h0,     32'h0);
      vt[1]  = mk(0, 0, 32'h0,  32'h0,      0, 0, 32'h0,  32'h0,      32'h1234,    0, 0, 32'h0,  32'h0,      2'b00, 0, 0, 32'h0,     32'h0);
      vt[2]  = mk(1, 0, 32'h10, 32'haaaa,   0, 0, 32'h0,  32'h0,      32'hdead,    1, 0, 32'h10, 32'h0,      2'b01, 0, 0, 32'h0,     32'h0);
      vt[3]  = mk(1, 0, 32'h10, 32'haaaa,   0, 0, 32'h0,  32'h0,      32'hdead,    1, 0, 32'h10, 32'h0,      2'b01, 0, 0, 32'h0,     32'h0);
      vt[4]  = mk(1, 0, 32'h10, 32'haaaa,   0, 0, 32'h0,  32'h0,      32'hdead,    1, 0, 32'h10, 32'h0,      2'b01, 0, 0, 32'h0,     32'h0);
      vt[5]  = mk(1, 0, 32'h10, 32'haaaa,   0, 0, 32'h0,  32'h0,      32'h22b4,    0, 0, 32'h0,  32'h0,      2'b00, 1, 0, 32'h22b4,  32'h0);
      vt[6]  = mk(0, 0, 32'h0,  32'h0,      0, 0, 32'h0,  32'h0,      32'h0,       0, 0, 32'h0,  32'h0,      2'b00, 0, 0, 32'h22b4,  32'h0);
      vt[7]  = mk(0, 0, 32'h0,  32'h0,      1, 1, 32'h20, 32'h064f,   32'h9999,    1, 1, 32'h20, 32'h064f,   2'b10, 0, 0, 32'h22b4,  32'h0);
      vt[8]  = mk(0, 0, 32'h0,  32'h0,      1, 1, 32'h20, 32'h064f,   32'h9999,    1, 1, 32'h20, 32'h064f,   2'b10, 0, 0, 32'h22b4,  32'h0);
      vt[9]  = mk(0, 0, 32'h0,  32'h0,      1, 1, 32'h20, 32'h064f,   32'h9999,    1, 1, 32'h20, 32'h064f,   2'b10, 0, 0, 32'h22b4,  32'h0);
      vt[10] = mk(0, 0, 32'h0,  32'h0,      1, 1, 32'h20, 32'h064f,   32'h9999,    0, 0, 32'h0,  32'h0,      2'b00, 0, 1, 32'h22b4,  32'h0);
      vt[11] = mk(0, 0, 32'h0,  32'h0,      0, 0, 32'h0,  32'h0,      32'h0,       0, 0, 32'h0,  32'h0,      2'b00, 0, 0, 32'h22b4,  32'h0);
      vt[12] = mk(1, 0, 32'h30, 32'h0,      0, 0, 32'h0,  32'h0,      32'h0,       1, 0, 32'h30, 32'h0,      2'b01, 0, 0, 32'h22b4,  32'h0);
      vt[13] = mk(0, 1, 32'h44, 32'hffff,   0, 0, 32'h0,  32'h0,      32'h0,       1, 0, 32'h30, 32'h0,      2'b01, 0, 0, 32'h22b4,  32'h0);
      vt[14] = mk(0, 1, 32'h44, 32'hffff,   0, 0, 32'h0,  32'h0,      32'h0,       1, 0, 32'h30, 32'h0,      2'b01, 0, 0, 32'h22b4,  32'h0);
      vt[15] = mk(0, 1, 32'h44, 32'hffff,   0, 0, 32'h0,  32'h0,      32'h5a5a,    0, 0, 32'h0,  32'h0,      2'b00, 1, 0, 32'h5a5a,  32'h0);
      vt[16] = mk(0, 0, 32'h0,  32'h0,      0, 0, 32'h0,  32'h0,      32'h0,       0, 0, 32'h0,  32'h0,      2'b00, 0, 0, 32'h5a5a,  32'h0);

      reset = 1'b0;
      m0_req = 0; m0_wr_rd = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_wr_rd = 0; m1_addr = 0; m1_wdata = 0;
      dbr = 0;

      #50;
      check("rst cs", 32'(cs), 0);
      check("rst gnt", 32'(gnt), 0);
      check("rst addr", addr, 0);
      check("rst ready", 32'({m1_ready, m0_ready}), 0);
      check("rst rdata", m0_rdata | m1_rdata, 0);
      check("rst z_cs", 32'(z_cs), 0);
      #50;
      reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge CLK);
         m0_req = vt[i].m0_req; m0_wr_rd = vt[i].m0_wr; m0_addr = vt[i].m0_addr; m0_wdata = vt[i].m0_wdata;
         m1_req = vt[i].m1_req; m1_wr_rd = vt[i].m1_wr; m1_addr = vt[i].m1_addr; m1_wdata = vt[i].m1_wdata;
         dbr = vt[i].dbr;
         @(posedge CLK); #1;
         check($sformatf("row%0d cs", i), 32'(cs), 32'(vt[i].e_cs));
         check($sformatf("row%0d wr_rd", i), 32'(wr_rd), 32'(vt[i].e_wr));
         check($sformatf("row%0d addr", i), addr, vt[i].e_addr);
         check($sformatf("row%0d dbw", i), dbw, vt[i].e_dbw);
         check($sformatf("row%0d gnt", i), 32'(gnt), 32'(vt[i].e_gnt));
         check($sformatf("row%0d m0_ready", i), 32'(m0_ready), 32'(vt[i].e_r0));
         check($sformatf("row%0d m1_ready", i), 32'(m1_ready), 32'(vt[i].e_r1));
         check($sformatf("row%0d m0_rdata", i), m0_rdata, vt[i].e_rd0);
         check($sformatf("row%0d m1_rdata", i), m1_rdata, vt[i].e_rd1);
      end

      // Simultaneous requests straight after reset, both kept high: strict alternation from m0.
      @(negedge CLK); reset = 1'b0;
      @(negedge CLK); reset = 1'b1;
      @(negedge CLK);
      m0_req = 1; m0_wr_rd = 0; m0_addr = 32'h100;
      m1_req = 1; m1_wr_rd = 0; m1_addr = 32'h200;
      for (int t = 0; t < 4; t++) begin
         wait_for(0, $sformatf("rr%0d cs", t));
         check($sformatf("rr%0d gnt", t), 32'(gnt), (t % 2) ? 32'd2 : 32'd1);
         check($sformatf("rr%0d addr", t), addr, (t % 2) ? 32'h200 : 32'h100);
         wait_for(1, $sformatf("rr%0d ready", t));
         check($sformatf("rr%0d ready", t), 32'({m1_ready, m0_ready}), (t % 2) ? 32'd2 : 32'd1);
      end

      // Fifth grant goes to m0; reset lands in its second ACCESS cycle.
      wait_for(0, "ar cs");
      check("ar gnt", 32'(gnt), 32'd1);
      @(posedge CLK); #2;
      check("ar cs before reset", 32'(cs), 32'd1);
      reset = 1'b0;
      #1;
      check("ar cs in reset", 32'(cs), 0);
      check("ar gnt in reset", 32'(gnt), 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge CLK); #1;
         check($sformatf("ar no ready %0d", k), 32'({m1_ready, m0_ready}), 0);
      end
      @(negedge CLK); reset = 1'b1;
      @(posedge CLK); #1;
      check("ar regrant cs", 32'(cs), 32'd1);
      check("ar regrant gnt", 32'(gnt), 32'd1);
      @(negedge CLK);
      m0_req = 0; m1_req = 0;
      wait_for(1, "ar ready");
      check("ar ready m0", 32'({m1_ready, m0_ready}), 32'd1);
      check("gnt onehot", 32'(bad_gnt), 0);

      // Zero wait states: single-cycle ACCESS.
      @(negedge CLK); reset = 1'b0;
      @(negedge CLK); reset = 1'b1;
      @(negedge CLK);
      m0_req = 1; m0_wr_rd = 0; m0_addr = 32'h40; dbr = 32'h77;
      @(posedge CLK); #1;
      check("ws0 cs", 32'(z_cs), 32'd1);
      check("ws0 addr", z_addr, 32'h40);
      check("ws0 gnt", 32'(z_gnt), 32'd1);
      @(posedge CLK); #1;
      check("ws0 cs end", 32'(z_cs), 0);
      check("ws0 ready", 32'(z_m0_ready), 32'd1);
      check("ws0 rdata", z_m0_rdata, 32'h77);
      @(negedge CLK);
      m0_req = 0;
      @(posedge CLK); #1;
      check("ws0 ready pulse", 32'(z_m0_ready), 0);
      check("ws0 idle cs", 32'(z_cs), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
